// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// FSM state encodings and VEC register layout.
package irq_ctrl_pkg;

   localparam int unsigned IRQ_ID_W    = 3;
   localparam int unsigned IRQ_VEC_VLD = 31;

   localparam logic [1:0] IRQ_MASK = 2'd0;
   localparam logic [1:0] IRQ_PEND = 2'd1;
   localparam logic [1:0] IRQ_MODE = 2'd2;
   localparam logic [1:0] IRQ_VEC  = 2'd3;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_REQ  = 2'd1,
      IRQ_SVC  = 2'd2
   } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Bridge register bus plus the CP0 request/acknowledge/return handshake.
interface irq_ctrl_if;

   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        ack;
   logic        eret;
   logic        irq_out;

   modport master (output Addr, WE, Din, ack, eret, input Dout, irq_out);
   modport slave  (input Addr, WE, Din, ack, eret, output Dout, irq_out);

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, 'any' flags a request.
module irq_prio_enc #(
   parameter int unsigned N_SRC = 6
) (
   input  logic [N_SRC-1:0] req,
   output logic [2:0]       id,
   output logic             any
);

   // Scan from the top so the lowest set index is the last one written
   always_comb begin
      id  = '0;
      any = |req;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (req[i]) id = 3'(i);
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Programmable interrupt controller: pending/mask registers, fixed-priority
// selection and a request/ack/eret handshake towards CP0.
// Optional feature macro IRQ_EDGE_EN: enables the MODE register, edge
// detection and write-1-to-clear of edge pending bits.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_src,
   irq_ctrl_if.slave        bus
);

   logic [N_SRC-1:0] src_q;
   logic [N_SRC-1:0] mask_q;
   logic [N_SRC-1:0] mode;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] act;
   logic [N_SRC-1:0] w1c;
   logic [N_SRC-1:0] ack_clr;
   logic [2:0]       enc_id;
   logic             enc_any;
   logic [2:0]       vec_id_q, vec_id_nxt;
   logic             vec_vld_q, vec_vld_nxt;
   logic             ack_take;
   logic             irq_nxt;
   irq_state_e       state_q, state_nxt;
   logic [31:0]      dout_c;

   logic [1:0] reg_sel;
   logic       wr_mask, wr_pend, wr_mode;

   assign reg_sel = bus.Addr[3:2];
   assign wr_mask = bus.WE && (reg_sel == IRQ_MASK);
   assign wr_pend = bus.WE && (reg_sel == IRQ_PEND);
   assign wr_mode = bus.WE && (reg_sel == IRQ_MODE);
   assign w1c     = wr_pend ? bus.Din[N_SRC-1:0] : '0;

   logic unused_bus;
   assign unused_bus = ^{bus.Addr[31:4], bus.Din};

   // Source sampling stage and mask register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q  <= '0;
         mask_q <= '0;
      end else begin
         src_q <= irq_src;
         if (wr_mask) mask_q <= bus.Din[N_SRC-1:0];
      end
   end

`ifdef IRQ_EDGE_EN
   logic [N_SRC-1:0] mode_q, pend_edge_q, rise;

   assign rise = irq_src & ~src_q;

   // Mode register and edge pending bits; a new edge beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= '0;
         pend_edge_q <= '0;
      end else begin
         if (wr_mode) mode_q <= bus.Din[N_SRC-1:0];
         pend_edge_q <= (rise | (pend_edge_q & ~(w1c | ack_clr))) & mode_q;
      end
   end

   assign mode = mode_q;
   assign pend = (mode_q & pend_edge_q) | (~mode_q & src_q);
`else
   logic unused_edge;
   assign unused_edge = ^{w1c, ack_clr, wr_mode};
   assign mode = '0;
   assign pend = src_q;
`endif

   assign act = pend & mask_q;

   irq_prio_enc #(.N_SRC(N_SRC)) u_enc (
      .req (act),
      .id  (enc_id),
      .any (enc_any)
   );

   // One-hot clear of the source taken by ack
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         ack_clr[i] = ack_take && (enc_id == 3'(i));
      end
   end

   // Handshake FSM next state, in-service vector and request output
   always_comb begin
      state_nxt   = state_q;
      vec_id_nxt  = vec_id_q;
      vec_vld_nxt = vec_vld_q;
      ack_take    = 1'b0;
      case (state_q)
         IRQ_IDLE: if (enc_any) state_nxt = IRQ_REQ;
         IRQ_REQ: begin
            if (!enc_any) begin
               state_nxt = IRQ_IDLE;
            end else if (bus.ack) begin
               state_nxt   = IRQ_SVC;
               vec_id_nxt  = enc_id;
               vec_vld_nxt = 1'b1;
               ack_take    = 1'b1;
            end
         end
         IRQ_SVC: begin
            if (bus.eret) begin
               state_nxt   = IRQ_IDLE;
               vec_vld_nxt = 1'b0;
            end
         end
         default: state_nxt = IRQ_IDLE;
      endcase
      irq_nxt = (state_nxt == IRQ_REQ);
   end

   // FSM state, VEC and registered request line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IRQ_IDLE;
         vec_id_q    <= '0;
         vec_vld_q   <= 1'b0;
         bus.irq_out <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         vec_id_q    <= vec_id_nxt;
         vec_vld_q   <= vec_vld_nxt;
         bus.irq_out <= irq_nxt;
      end
   end

   // Register read mux
   always_comb begin
      dout_c = '0;
      case (reg_sel)
         IRQ_MASK: dout_c = 32'(mask_q);
         IRQ_PEND: dout_c = 32'(pend);
         IRQ_MODE: dout_c = 32'(mode);
         IRQ_VEC: begin
            dout_c[IRQ_VEC_VLD] = vec_vld_q;
            dout_c[2:0]         = vec_id_q;
         end
         default: dout_c = '0;
      endcase
   end

   assign bus.Dout = dout_c;

endmodule
